// File: rtl/imem_pkg.sv
// imem_pkg: shared state type, fill constant and address helper
// for the instruction memory controller.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } imem_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: fetch and program-load bundle for instr_mem_ctrl.
// Parity signals exist only when IMEM_PARITY_EN is defined.
interface instr_mem_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_instr;
    logic            fetch_fault;
    logic            load_start;
    logic [31:0]     load_base;
    logic [CW-1:0]   load_count;
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            load_ready;
    logic            load_done;
    logic            busy;
`ifdef IMEM_PARITY_EN
    logic            par_inject;
    logic            fetch_parity_err;
`endif

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_fault,
        output load_start,
        output load_base,
        output load_count,
        output load_valid,
        output load_data,
        input  load_ready,
        input  load_done,
`ifdef IMEM_PARITY_EN
        output par_inject,
        input  fetch_parity_err,
`endif
        input  busy
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_valid,
        output fetch_instr,
        output fetch_fault,
        input  load_start,
        input  load_base,
        input  load_count,
        input  load_valid,
        input  load_data,
        output load_ready,
        output load_done,
`ifdef IMEM_PARITY_EN
        input  par_inject,
        output fetch_parity_err,
`endif
        output busy
    );

endinterface

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x W storage, one synchronous write port and
// one registered read port whose output register resets to zero.
module imem_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with reset-time clear, streaming
// loader and faulting fetch port. Optional parity: IMEM_PARITY_EN.
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 64,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_DEFAULT)
) (
    input logic            clk,
    input logic            reset,
    instr_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int W = XLEN + 1;
`else
    localparam int W = XLEN;
`endif

    imem_state_t     r_state;
    imem_state_t     w_next;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_ptr;
    logic [AW:0]     r_rem;
    logic            r_done;
    logic            r_fvalid;
    logic            r_fault;
    logic            w_beat;
    logic            w_we;
    logic            w_re;
    logic            w_fault;
    logic [AW-1:0]   w_waddr;
    logic [AW-1:0]   w_raddr;
    logic [XLEN-1:0] w_wword;
    logic [W-1:0]    w_wdata;
    logic [W-1:0]    w_rdata;
    logic [29:0]     w_widx;
    logic            w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_beat = (r_state == LOAD) && bus.load_valid;

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wword = NOP_WORD;
        unique case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_idx == AW'(DEPTH - 1)) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (bus.load_start && bus.load_count != '0) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_we    = bus.load_valid;
                w_waddr = r_ptr;
                w_wword = bus.load_data;
                if (bus.load_valid && r_rem == (AW + 1)'(1)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = CLEAR;
        endcase
    end

    // Clear index, burst pointer/remaining count and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_ptr  <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == CLEAR) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == IDLE && bus.load_start) begin
                r_ptr  <= bus.load_base[2 +: AW];
                r_rem  <= bus.load_count;
                r_done <= (bus.load_count == '0);
            end
            if (w_beat) begin
                r_ptr  <= r_ptr + 1'b1;
                r_rem  <= r_rem - 1'b1;
                r_done <= (r_rem == (AW + 1)'(1));
            end
        end
    end

    assign w_widx  = word_idx(bus.fetch_addr);
    assign w_fault = (bus.fetch_addr[1:0] != 2'b00)
                  || ({2'b00, w_widx} >= 32'(DEPTH))
                  || (r_state != IDLE);
    assign w_re    = bus.fetch_req && !w_fault;
    assign w_raddr = w_widx[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fvalid <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_fvalid <= bus.fetch_req;
            if (bus.fetch_req) begin
                r_fault <= w_fault;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    // Stored bit makes the word even parity; injection flips it on load.
    assign w_wdata = {(^w_wword) ^ (w_beat & bus.par_inject), w_wword};
    assign bus.fetch_parity_err =
        !r_fault && ((^w_rdata[XLEN-1:0]) != w_rdata[XLEN]);
`else
    assign w_wdata = w_wword;
`endif

    imem_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we && !reset),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.fetch_valid = r_fvalid;
    assign bus.fetch_fault = r_fault;
    assign bus.fetch_instr = r_fault ? NOP_WORD : w_rdata[XLEN-1:0];
    assign bus.load_ready  = (r_state == LOAD);
    assign bus.load_done   = r_done;
    assign bus.busy        = (r_state != IDLE);

    assign w_unused = ^{bus.load_base[31:2+AW], bus.load_base[1:0]};

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory with a synchronous fetch port and a streaming program-load port. It replaces fixed hardcoded contents with three things: a reset-time clear sequencer, a valid/ready loader FSM that writes consecutive words from a base address, and fault reporting on fetch. It sits between the PC/fetch stage and the testbench or boot loader that supplies program images.

Parameters:
XLEN, 32, instruction word width
DEPTH, 64, number of words (power of two, at least 4)
NOP_WORD, 32'h00000013, fill value written during clear (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch request, one per cycle allowed
fetch_addr  in  32  byte address of the instruction
fetch_valid  out  1  response strobe, one cycle after fetch_req
fetch_instr  out  XLEN  fetched word (NOP_WORD on fault)
fetch_fault  out  1  misaligned, out-of-range, or busy fetch
load_start  in  1  begin a load burst (sampled in IDLE only)
load_base  in  32  byte base address; bits [1:0] ignored
load_count  in  $clog2(DEPTH)+1  number of words in the burst
load_valid  in  1  load beat valid
load_data  in  XLEN  load beat data
load_ready  out  1  high throughout LOAD
load_done  out  1  one-cycle pulse at end of burst
busy  out  1  high in CLEAR or LOAD

Behaviour:
- Reset (takes priority over everything, including mid-burst): state enters CLEAR, clear index 0.
- Reset output values: fetch_valid=0, fetch_instr=0, fetch_fault=0, load_ready=0, load_done=0, busy=1.
- CLEAR: writes NOP_WORD to mem[idx] each cycle, idx++. After DEPTH cycles (idx=DEPTH-1 written), go to IDLE. busy falls on the first IDLE cycle.
- IDLE, load_start with load_count>0: go to LOAD. ptr=load_base[2+:$clog2(DEPTH)], remaining=load_count.
- IDLE, load_start with load_count==0: load_done pulses next cycle, state stays IDLE.
- load_start in CLEAR or LOAD is ignored.
- LOAD: load_ready=1. Each cycle with load_valid&&load_ready: mem[ptr]<=load_data, ptr=(ptr+1) mod DEPTH (wraps), remaining--.
- LOAD, beat with remaining==1: next state IDLE, load_done=1 for exactly that next cycle, load_ready=0.
- load_valid while load_ready=0 is ignored; no beat is consumed.
- Fetch latency is 1 cycle: response registered from the cycle fetch_req=1; fetch_valid=0 otherwise. fetch_instr/fetch_fault hold their last value when fetch_valid=0.
- Fault when any of: fetch_addr[1:0]!=0, fetch_addr[31:2]>=DEPTH, or state!=IDLE. On fault: fetch_instr=NOP_WORD, fetch_fault=1, memory not read.
- Otherwise fetch_instr=mem[fetch_addr[31:2]], fetch_fault=0.
- No read/write collision is possible, because fetches are served only in IDLE.

Optional Feature:
IMEM_PARITY_EN. When defined:
- Each word stores an extra even-parity bit, computed on every write (clear and load).
- New input par_inject (1): when high during a load beat, the stored parity bit is inverted.
- New output fetch_parity_err (1): valid with fetch_valid; 1 when the recomputed parity mismatches on a non-fault fetch, 0 on fault; reset value 0. fetch_instr still returns the stored data.
When undefined: no parity storage, no par_inject or fetch_parity_err ports.

Decomposition:
- Package imem_pkg holds:
  - imem_state_t enum {CLEAR, IDLE, LOAD}
  - NOP_WORD default constant
  - function word_idx(addr) returning addr[31:2]
- One sub-module, imem_ram: DEPTH x (XLEN+parity) array with one synchronous write port and one registered read port.
- The FSM, counters and fault logic stay in instr_mem_ctrl.

Test Plan:
- reset 1 cycle, release -> busy=1 for 64 cycles then 0; fetch 0x10 -> next cycle fetch_valid=1, instr=0x00000013, fault=0.
- load_base=0x4, count=3, data 0x00500113/0x00C00193/0xFF718393 with a one-cycle load_valid gap -> load_done pulses one cycle after the third beat; fetch 0x8 -> 0x00C00193; fetch 0x0 -> 0x00000013.
- load_base=0xFC, count=2, data 0xAAAA0001/0xBBBB0002 -> fetch 0xFC=0xAAAA0001, fetch 0x0=0xBBBB0002 (wrap).
- Fetch faults: fetch 0x102 -> fault=1, instr=0x13; fetch 0x100 -> fault=1; fetch during LOAD -> fault=1; fetch during CLEAR -> fault=1.
- reset asserted after beat 1 of a 3-beat load -> load_ready=0, busy=1, re-clear; afterwards all 64 words read 0x13 and no load_done pulse is seen.
- With IMEM_PARITY_EN: load word 0x12345678 at 0x20 with par_inject=1 -> fetch 0x20 gives instr=0x12345678, fetch_parity_err=1; a clean word gives 0.
